// File: rtl/sparse_round_sequencer.sv
// Sparse round sequencer: walks sparse memory entries and launches one
// controller round per entry, flagging dummy rounds and out-of-range entries.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start_i              begin a sequence (ignored while busy)
//   num_entries_i        entry count, sampled on start_i
//   sparse_mem_addr_o    sparse memory read address (1-cycle latency)
//   sparse_mem_data_i    sparse memory read data
//   ctrl_start_o         1-cycle launch pulse to the controller
//   ctrl_done_i          controller process done
//   ctrl_busy_i          controller busy
//   dummy_o              current round is a dummy round
//   round_cnt_o          rounds completed (real + dummy)
//   busy_o               sequence in progress
//   done_o               1-cycle pulse at sequence end
//   err_o                sticky range / timeout / clamp error
module sparse_round_sequencer #(
    parameter int                    WORD_WIDTH      = 32,
    parameter int                    MEM_SPARSE_SIZE = 50,
    parameter int                    POLY_BITS       = 17669,
    parameter logic [WORD_WIDTH-1:0] DUMMY_WORD      = 32'hFFFFFFFF,
    parameter int                    DONE_TIMEOUT    = 4095
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [5:0]            num_entries_i,
    output logic [9:0]            sparse_mem_addr_o,
    input  logic [WORD_WIDTH-1:0] sparse_mem_data_i,
    output logic                  ctrl_start_o,
    input  logic                  ctrl_done_i,
    input  logic                  ctrl_busy_i,
    output logic                  dummy_o,
    output logic [5:0]            round_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int HW = WORD_WIDTH / 2;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [HW-1:0] POS_LIM = HW'(POLY_BITS);
    localparam logic [5:0]    MAX_N   = 6'(MEM_SPARSE_SIZE);
    localparam logic [TW-1:0] TMO     = TW'(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_CHECK,
        S_LAUNCH,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [5:0]    n_q;
    logic [5:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic [5:0]    cnt_q;
    logic          dummy_q;
    logic          err_q;

    logic is_dummy;
    logic bad_pos;
    logic last_entry;
    logic timed_out;

    assign is_dummy   = (sparse_mem_data_i == DUMMY_WORD);
    assign bad_pos    = (sparse_mem_data_i[WORD_WIDTH-1:HW] >= POS_LIM) ||
                        (sparse_mem_data_i[HW-1:0] >= POS_LIM);
    assign last_entry = (idx_q == n_q - 6'd1);
    assign timed_out  = (timer_q == TMO);

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (num_entries_i == 6'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH:     state_nxt = S_WAIT_DATA;
            S_WAIT_DATA: state_nxt = S_CHECK;
            S_CHECK: begin
                // A dummy word also fails the range test, so test it first
                if (!is_dummy && bad_pos) begin
                    state_nxt = S_NEXT;
                end else if (!ctrl_busy_i) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH:    state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ctrl_done_i) begin
                    state_nxt = S_NEXT;
                end else if (timed_out) begin
                    state_nxt = S_FINISH;
                end
            end
            S_NEXT:      state_nxt = last_entry ? S_FINISH : S_FETCH;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            dummy_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        n_q     <= (num_entries_i > MAX_N) ? MAX_N : num_entries_i;
                        err_q   <= (num_entries_i > MAX_N);
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        dummy_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!is_dummy && bad_pos) begin
                        err_q <= 1'b1;
                    end else begin
                        dummy_q <= is_dummy;
                    end
                end
                S_LAUNCH: timer_q <= '0;
                S_WAIT_DONE: begin
                    if (ctrl_done_i) begin
                        cnt_q <= cnt_q + 6'd1;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        dummy_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_NEXT: begin
                    dummy_q <= 1'b0;
                    idx_q   <= idx_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Address follows idx, which only moves in NEXT, so it is stable
    // from CHECK through WAIT_DONE.
    assign sparse_mem_addr_o = 10'(idx_q);
    assign ctrl_start_o      = (state_q == S_LAUNCH);
    assign done_o            = (state_q == S_FINISH);
    assign busy_o            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign dummy_o           = dummy_q;
    assign round_cnt_o       = cnt_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_sparse_round_sequencer.sv
// Testbench for sparse_round_sequencer: scoreboard of expected launches
// and sequence results against a behavioural model, plus directed cases.
module tb_sparse_round_sequencer;

    localparam int TMO = 4095;
    localparam int PB  = 17669;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  num_entries_i = '0;
    logic [9:0]  sparse_mem_addr_o;
    logic [31:0] sparse_mem_data_i = '0;
    logic        ctrl_start_o;
    logic        ctrl_done_i = 1'b0;
    logic        ctrl_busy_i;
    logic        dummy_o;
    logic [5:0]  round_cnt_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    sparse_round_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .num_entries_i     (num_entries_i),
        .sparse_mem_addr_o (sparse_mem_addr_o),
        .sparse_mem_data_i (sparse_mem_data_i),
        .ctrl_start_o      (ctrl_start_o),
        .ctrl_done_i       (ctrl_done_i),
        .ctrl_busy_i       (ctrl_busy_i),
        .dummy_o           (dummy_o),
        .round_cnt_o       (round_cnt_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; bit dmy; } launch_t;
    typedef struct { int cnt; bit err; } fin_t;

    launch_t exp_l[$];
    fin_t    exp_d[$];

    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launches_seen = 0;
    int done_seen = 0;
    int last_launch_cyc = 0;
    int done_cyc = 0;
    bit ctrl_hang = 1'b0;
    int fixed_lat = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency
    always @(posedge clk) sparse_mem_data_i <= mem[sparse_mem_addr_o[5:0]];

    // Controller model: done pulse after a latency, optional busy tail
    logic       run = 1'b0;
    int         cnt_c = 0;
    int         tail = 0;
    assign ctrl_busy_i = run || (tail > 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt_c <= 0;
            tail <= 0;
            ctrl_done_i <= 1'b0;
        end else begin
            ctrl_done_i <= 1'b0;
            if (ctrl_start_o) begin
                run <= 1'b1;
                cnt_c <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 12));
            end else if (run) begin
                if (cnt_c <= 1) begin
                    if (!ctrl_hang) begin
                        run <= 1'b0;
                        ctrl_done_i <= 1'b1;
                        tail <= int'($urandom_range(0, 3));
                    end
                end else begin
                    cnt_c <= cnt_c - 1;
                end
            end else if (tail > 0) begin
                tail <= tail - 1;
            end
        end
    end

    // Monitor: compare each launch and each sequence end with the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (ctrl_start_o) begin
                launch_t e;
                launches_seen++;
                last_launch_cyc = cyc;
                if (exp_l.size() == 0) begin
                    check("launch_extra", 32'(1), 32'(0));
                end else begin
                    e = exp_l.pop_front();
                    check("launch_addr", 32'(sparse_mem_addr_o), 32'(e.addr));
                    check("launch_dummy", 32'(dummy_o), 32'(e.dmy));
                end
            end
            if (done_o) begin
                fin_t f;
                done_seen++;
                done_cyc = cyc;
                if (exp_d.size() == 0) begin
                    check("done_extra", 32'(1), 32'(0));
                end else begin
                    f = exp_d.pop_front();
                    check("round_cnt", 32'(round_cnt_o), 32'(f.cnt));
                    check("err", 32'(err_o), 32'(f.err));
                    check("launch_missing", 32'(exp_l.size()), 32'(0));
                    check("busy_at_done", 32'(busy_o), 32'(0));
                    exp_l.delete();
                end
            end
        end
    end

    // Behavioural model of one sequence
    task automatic model(input int n, input bit hang, output int nl);
        int ne;
        bit e;
        int c;
        logic [31:0] w;
        nl = 0;
        ne = n;
        e = 1'b0;
        c = 0;
        if (ne > 50) begin
            ne = 50;
            e = 1'b1;
        end
        for (int i = 0; i < ne; i++) begin
            w = mem[i];
            if (w == 32'hFFFFFFFF || (w[31:16] < PB && w[15:0] < PB)) begin
                exp_l.push_back('{addr: i, dmy: (w == 32'hFFFFFFFF)});
                nl++;
                if (hang) begin
                    e = 1'b1;
                    break;
                end
                c++;
            end else begin
                e = 1'b1;
            end
        end
        exp_d.push_back('{cnt: c, err: e});
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        num_entries_i = 6'(n);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_seq(input int n, input bit hang, input bit inject);
        int nl;
        int d0;
        int l0;
        ctrl_hang = hang;
        model(n, hang, nl);
        d0 = done_seen;
        l0 = launches_seen;
        pulse_start(n);
        if (inject && nl >= 2) begin
            for (int k = 0; k < 500 && launches_seen == l0; k++) @(posedge clk);
            pulse_start(int'($urandom_range(0, 63)));
        end
        for (int k = 0; k < 9000 && done_seen == d0; k++) @(posedge clk);
        if (done_seen == d0) begin
            check("done_wait", 32'(0), 32'(1));
            exp_l.delete();
            exp_d.delete();
        end
        ctrl_hang = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) mem[i] = 32'hFFFFFFFF;
            else if (r == 1) begin
                if ($urandom_range(0, 1) == 1)
                    mem[i] = {16'($urandom_range(PB, 65534)), 16'($urandom_range(0, PB - 1))};
                else
                    mem[i] = {16'($urandom_range(0, PB - 1)), 16'($urandom_range(PB, 65535))};
            end else if (r == 2) mem[i] = {16'(PB - 1), 16'(PB - 1)};
            else mem[i] = {16'($urandom_range(0, PB - 1)), 16'($urandom_range(0, PB - 1))};
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctrl_start"}, 32'(ctrl_start_o), 32'(0));
        check({tag, "_busy"}, 32'(busy_o), 32'(0));
        check({tag, "_done"}, 32'(done_o), 32'(0));
        check({tag, "_err"}, 32'(err_o), 32'(0));
        check({tag, "_dummy"}, 32'(dummy_o), 32'(0));
        check({tag, "_round_cnt"}, 32'(round_cnt_o), 32'(0));
        check({tag, "_addr"}, 32'(sparse_mem_addr_o), 32'(0));
    endtask

    initial begin
        int l0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: three real entries, controller latency 20
        fixed_lat = 20;
        mem[0] = 32'h0005_0040;
        mem[1] = 32'h1000_2000;
        mem[2] = 32'h0001_0002;
        run_seq(3, 1'b0, 1'b0);

        // 2: second entry dummy
        mem[1] = 32'hFFFFFFFF;
        run_seq(2, 1'b0, 1'b0);

        // 3: range boundary, second entry out of range
        mem[0] = 32'h4500_0010;
        mem[1] = 32'h4521_0000;
        run_seq(2, 1'b0, 1'b0);

        // 4: controller hangs -> timeout abort
        mem[0] = 32'h0000_0001;
        run_seq(1, 1'b1, 1'b0);
        check("timeout_cycles", 32'(done_cyc - last_launch_cyc), 32'(TMO + 2));

        // 5: zero entries
        l0 = launches_seen;
        run_seq(0, 1'b0, 1'b0);
        check("zero_no_launch", 32'(launches_seen - l0), 32'(0));

        // 6: reset during WAIT_DONE of round 2
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;
        begin
            int nl;
            model(3, 1'b0, nl);
        end
        l0 = launches_seen;
        pulse_start(3);
        for (int k = 0; k < 500 && launches_seen < l0 + 2; k++) @(posedge clk);
        check("rst_reached_round2", 32'(launches_seen - l0), 32'(2));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midrst");
        exp_l.delete();
        exp_d.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_seq(2, 1'b0, 1'b0);

        // Clamp: more than 50 entries
        fixed_lat = 0;
        fill_random();
        run_seq(55, 1'b0, 1'b0);

        // Randomized sequences with ignored mid-run starts
        for (int s = 0; s < 20; s++) begin
            int n;
            fill_random();
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(48, 63))
                                            : int'($urandom_range(0, 12));
            run_seq(n, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
